data_bus_responder: RTL and testbench
=====================================

// Module: data_bus_responder
// PURPOSE
// - Data-memory responder at the far end of the CPU load/store bus: samples the multicycle
//   core's bus request (address, write enable, write data, func3), waits WAIT_STATES cycles,
//   then commits the store or returns the load data with a one-cycle busReady pulse.
// - Performs RV32I byte/half/word lane steering on stores and sign/zero extension on loads,
//   so the core's writeback path receives final 32-bit register data.
// PARAMETERS
// - ADDR_W       10  byte-address width; array depth = 2**(ADDR_W-2) 32-bit words
// - WAIT_STATES  0   extra cycles between request accept and response (0..15)
// PORTS
// - clk        in   1       system clock, all state on rising edge
// - reset      in   1       asynchronous, active-low reset
// - busReq     in   1       request valid; sampled only in IDLE
// - busWe      in   1       1 = store, 0 = load
// - busAddr    in   ADDR_W  byte address
// - busWData   in   32      store data, right-aligned (SB uses [7:0], SH uses [15:0])
// - func3      in   3       RV32I width/sign code from instruction [14:12]
// - busReady   out  1       one-cycle response strobe
// - busRData   out  32      load result, valid only while busReady=1, otherwise 0
// - busErr     out  1       access fault, valid only while busReady=1
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, wait counter=0, busReady=0, busRData=0, busErr=0.
//   The memory array is not cleared. A transaction in flight is dropped, and its store is
//   not committed unless the commit edge has already occurred.
// - FSM:
//   - IDLE: on busReq=1, latch busWe/busAddr/busWData/func3. Go to WAIT if WAIT_STATES>0,
//     else go to RESP.
//   - WAIT: count 1..WAIT_STATES, then go to RESP.
//   - RESP: busReady=1 for exactly one cycle, then always go to IDLE.
// - Commit: the store write and the load read both happen on the clock edge that enters RESP.
//   Latency from accept edge to busReady is WAIT_STATES+1 cycles. Initiation interval is
//   WAIT_STATES+2 cycles.
// - busReq is ignored outside IDLE. The requester holds all inputs stable until busReady.
//   If busReq is still 1 in the IDLE cycle after RESP, it is a new request.
// - Store func3 lane steering (lane = addr[1:0]):
//   - 000 SB: write byte enable at the lane.
//   - 001 SH: write lanes {addr[1],0}+1 : {addr[1],0}.
//   - 010 SW: write all four lanes.
//   - Unwritten bytes are preserved.
// - Load func3:
//   - 000 LB: sign-extend the selected byte.
//   - 100 LBU: zero-extend the selected byte.
//   - 001 LH / 101 LHU: sign/zero-extend the selected halfword.
//   - 010 LW: full word.
// - Word index = busAddr[ADDR_W-1:2]. The address space wraps naturally; no out-of-range case.
// - busRData is 0 during a store response and in every cycle without busReady.
// CONFIGURATION
// - DBUS_ERR_EN defined:
//   - Faults are: misaligned halfword (addr[0]=1), misaligned word (addr[1:0]!=0), and
//     illegal func3 (011, 110, 111, or 1xx on a store).
//   - On a fault: no array write, busRData=0, busErr=1 together with busReady.
//   - Latency is unchanged.
// - DBUS_ERR_EN undefined:
//   - busErr is tied to 0.
//   - Misaligned accesses execute with the address forced to natural alignment
//     (low bits cleared).
//   - Illegal func3 is treated as a word access (LW/SW).
// TESTING
// - WAIT_STATES=0: SW 0x0000_0010 <- 0xDEADBEEF, then LW 0x10.
//   -> Each busReady arrives 1 cycle after accept; load returns 0xDEADBEEF, busErr=0.
// - SB 0x13 <- 0x80, then LB 0x13 and LBU 0x13.
//   -> Word 0x10 reads back 0x80ADBEEF; LB returns 0xFFFFFF80; LBU returns 0x00000080.
// - SH 0x12 <- 0x1234, then LH 0x12 and LHU 0x10.
//   -> Word becomes 0x1234BEEF; LH returns 0x00001234; LHU returns 0x0000BEEF.
// - WAIT_STATES=3: hold busReq=1 continuously for LW 0x10.
//   -> busReady pulses every 5 cycles; exactly one pulse per accept.
// - Assert reset=0 mid-WAIT during SW 0x20 <- 0x11111111, then LW 0x20.
//   -> Outputs go to 0 immediately; load returns the pre-reset contents.
// - With DBUS_ERR_EN: LW 0x11 -> busErr=1, busRData=0; SW 0x12 -> busErr=1, memory unchanged.
//   Without DBUS_ERR_EN: LW 0x11 returns word 0x10 with busErr=0.

Source files
------------

// File: rtl/data_bus_responder.sv
// -----------------------------------------------------------------------------
// data_bus_responder
// Data-memory responder at the far end of the CPU load/store bus. Accepts one
// request in IDLE, optionally waits WAIT_STATES cycles, then commits the store
// (byte/half/word lane steering) or returns the sign/zero-extended load data
// with a one-cycle busReady strobe.
//
// Parameters:
//   ADDR_W       byte-address width, array depth = 2**(ADDR_W-2) words
//   WAIT_STATES  extra cycles between accept and response (0..15)
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   busReq    in   request valid, sampled only in IDLE
//   busWe     in   1 = store, 0 = load
//   busAddr   in   byte address
//   busWData  in   right-aligned store data
//   func3     in   RV32I width/sign code
//   busReady  out  one-cycle response strobe
//   busRData  out  load result while busReady, else 0
//   busErr    out  access fault while busReady
//
// Build option:
//   DBUS_ERR_EN  defined: misaligned / illegal-func3 accesses fault (busErr=1,
//                no write, busRData=0). Undefined: busErr tied 0, accesses are
//                force-aligned and illegal func3 is treated as a word access.
// -----------------------------------------------------------------------------
module data_bus_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              busReq,
    input  logic              busWe,
    input  logic [ADDR_W-1:0] busAddr,
    input  logic [31:0]       busWData,
    input  logic [2:0]        func3,
    output logic              busReady,
    output logic [31:0]       busRData,
    output logic              busErr
);

    localparam int unsigned DEPTH = 2 ** (ADDR_W - 2);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        f3_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              commit;

    logic [31:0]       mem [DEPTH];

    // With WAIT_STATES=0 the accept edge is also the commit edge, so the
    // request is taken straight from the bus in IDLE, from the latches later.
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [2:0]        r_f3;

    logic              legal;
    logic [1:0]        size;
    logic [1:0]        lane;
    logic              fault;
    logic [3:0]        be;
    logic [31:0]       wword;
    logic [31:0]       lword;
    logic [31:0]       lshift;
    logic [ADDR_W-3:0] widx;

    always_comb begin
        r_we    = (state_q == S_IDLE) ? busWe    : we_q;
        r_addr  = (state_q == S_IDLE) ? busAddr  : addr_q;
        r_wdata = (state_q == S_IDLE) ? busWData : wdata_q;
        r_f3    = (state_q == S_IDLE) ? func3    : f3_q;
    end

    // Access decode: size 0=byte, 1=half, 2=word.
    always_comb begin
        legal = r_we ? (r_f3 inside {3'b000, 3'b001, 3'b010})
                     : (r_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        size  = legal ? r_f3[1:0] : 2'd2;
`ifdef DBUS_ERR_EN
        fault = !legal || (size == 2'd1 && r_addr[0]) ||
                (size == 2'd2 && r_addr[1:0] != 2'b00);
`else
        fault = 1'b0;
`endif
        // Clearing low bits forces natural alignment; for non-faulting
        // accesses in the error-checking build this is a no-op.
        case (size)
            2'd0:    lane = r_addr[1:0];
            2'd1:    lane = {r_addr[1], 1'b0};
            default: lane = 2'b00;
        endcase
        widx   = r_addr[ADDR_W-1:2];
        lword  = mem[widx];
        lshift = lword >> {lane, 3'b000};
        case (size)
            2'd0: begin
                be      = 4'b0001 << lane;
                wword   = {4{r_wdata[7:0]}};
                rdata_d = r_f3[2] ? {24'b0, lshift[7:0]} : {{24{lshift[7]}}, lshift[7:0]};
            end
            2'd1: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{r_wdata[15:0]}};
                rdata_d = r_f3[2] ? {16'b0, lshift[15:0]} : {{16{lshift[15]}}, lshift[15:0]};
            end
            default: begin
                be      = 4'b1111;
                wword   = r_wdata;
                rdata_d = lword;
            end
        endcase
        if (r_we || fault) begin
            rdata_d = '0;
        end
        err_d = fault;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (busReq) begin
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_STATES[3:0]) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The array shares this block so that no store can commit while reset is
    // held; it is deliberately never cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && busReq) begin
                we_q    <= busWe;
                addr_q  <= busAddr;
                wdata_q <= busWData;
                f3_q    <= func3;
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
                if (r_we && !fault) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (be[i]) begin
                            mem[widx][8*i +: 8] <= wword[8*i +: 8];
                        end
                    end
                end
            end
        end
    end

    assign busReady = (state_q == S_RESP);
    assign busRData = busReady ? rdata_q : '0;
    assign busErr   = busReady & err_q;

endmodule

// File: tb/tb_data_bus_responder.sv
module tb_data_bus_responder;

    localparam int W1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        req  [2];
    logic        we   [2];
    logic [9:0]  addr [2];
    logic [31:0] wd   [2];
    logic [2:0]  f3   [2];
    logic        rdy  [2];
    logic [31:0] rd   [2];
    logic        err  [2];

    always #5 clk = ~clk;

    data_bus_responder #(.ADDR_W(10), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .busReq(req[0]), .busWe(we[0]), .busAddr(addr[0]),
        .busWData(wd[0]), .func3(f3[0]), .busReady(rdy[0]), .busRData(rd[0]), .busErr(err[0])
    );

    data_bus_responder #(.ADDR_W(10), .WAIT_STATES(W1)) u1 (
        .clk(clk), .reset(reset), .busReq(req[1]), .busWe(we[1]), .busAddr(addr[1]),
        .busWData(wd[1]), .func3(f3[1]), .busReady(rdy[1]), .busRData(rd[1]), .busErr(err[1])
    );

    int ncmp = 0;
    int nfail = 0;

    // Byte-addressed reference memory per instance.
    logic [7:0] mm [2][1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: apply the access rules directly on a byte array.
    function automatic void model(input int s, input bit w, input logic [9:0] a,
                                  input logic [31:0] d, input logic [2:0] f,
                                  output logic [31:0] r, output bit e);
        bit legal;
        int nb;
        int base;
        logic [31:0] v;
        legal = w ? (f <= 3'd2) : (f != 3'd3 && f != 3'd6 && f != 3'd7);
        nb = legal ? (1 << f[1:0]) : 4;
        r = '0;
        e = 1'b0;
`ifdef DBUS_ERR_EN
        if (!legal || (int'(a) % nb) != 0) begin
            e = 1'b1;
            return;
        end
`endif
        base = int'(a) - (int'(a) % nb);
        if (w) begin
            for (int i = 0; i < nb; i++) mm[s][base+i] = d[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[s][base+i];
            if (nb < 4 && !f[2] && v[8*nb-1]) begin
                for (int j = nb; j < 4; j++) v[8*j +: 8] = 8'hFF;
            end
            r = v;
        end
    endfunction

    task automatic txn(input int s, input bit w, input logic [9:0] a, input logic [31:0] d,
                       input logic [2:0] f, output logic [31:0] r, output logic e,
                       output int lat);
        @(negedge clk);
        we[s] = w; addr[s] = a; wd[s] = d; f3[s] = f; req[s] = 1'b1;
        lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (rdy[s] === 1'b1) break;
            check("quiet_rdata", rd[s], 32'h0);
        end
        check("ready_seen", {31'b0, rdy[s]}, 32'h1);
        r = rd[s];
        e = err[s];
        req[s] = 1'b0;
    endtask

    task automatic txn_check(input int s, input bit w, input logic [9:0] a,
                             input logic [31:0] d, input logic [2:0] f);
        logic [31:0] r, er;
        logic e;
        bit ee;
        int lat;
        model(s, w, a, d, f, er, ee);
        txn(s, w, a, d, f, r, e, lat);
        check("rand_rdata", r, er);
        check("rand_err", {31'b0, e}, {31'b0, ee});
        check("rand_latency", lat, (s == 0) ? 1 : W1 + 1);
    endtask

    typedef struct {
        bit          we;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [31:0] r, er;
        logic e;
        bit ee;
        int lat, pulses, last;

        tbl[0]  = '{1'b1, 10'h010, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 10'h010, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 10'h013, 32'h00000080, 3'b000, 32'h0, 1'b0};
        tbl[3]  = '{1'b0, 10'h010, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0};
        tbl[4]  = '{1'b0, 10'h013, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0};
        tbl[5]  = '{1'b0, 10'h013, 32'h0,        3'b100, 32'h00000080, 1'b0};
        tbl[6]  = '{1'b1, 10'h012, 32'h00001234, 3'b001, 32'h0, 1'b0};
        tbl[7]  = '{1'b0, 10'h010, 32'h0,        3'b010, 32'h1234BEEF, 1'b0};
        tbl[8]  = '{1'b0, 10'h012, 32'h0,        3'b001, 32'h00001234, 1'b0};
        tbl[9]  = '{1'b0, 10'h010, 32'h0,        3'b101, 32'h0000BEEF, 1'b0};
`ifdef DBUS_ERR_EN
        tbl[10] = '{1'b0, 10'h011, 32'h0,        3'b010, 32'h0, 1'b1};
        tbl[11] = '{1'b1, 10'h012, 32'hCAFEF00D, 3'b010, 32'h0, 1'b1};
        tbl[12] = '{1'b0, 10'h010, 32'h0,        3'b010, 32'h1234BEEF, 1'b0};
`else
        tbl[10] = '{1'b0, 10'h011, 32'h0,        3'b010, 32'h1234BEEF, 1'b0};
        tbl[11] = '{1'b1, 10'h012, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0};
        tbl[12] = '{1'b0, 10'h010, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0};
`endif

        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wd[s] = '0; f3[s] = '0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", {31'b0, rdy[s]}, 32'h0);
            check("reset_rdata", rd[s], 32'h0);
            check("reset_err",   {31'b0, err[s]}, 32'h0);
        end
        reset = 1'b1;

        // Directed vectors on the zero-wait instance.
        foreach (tbl[i]) begin
            model(0, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].f3, er, ee);
            txn(0, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].f3, r, e, lat);
            check($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rd);
            check($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, 1);
        end

        // Fill every word, then random accesses against the model.
        for (int wi = 0; wi < 256; wi++) txn_check(0, 1'b1, 10'(wi * 4), $urandom, 3'b010);
        for (int n = 0; n < 300; n++) begin
            txn_check(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
                      $urandom, 3'($urandom_range(0, 7)));
        end

        // Wait-state instance: back-to-back accepts with busReq held high.
        txn_check(1, 1'b1, 10'h010, 32'h5A5A1234, 3'b010);
        @(negedge clk);
        we[1] = 1'b0; addr[1] = 10'h010; wd[1] = '0; f3[1] = 3'b010; req[1] = 1'b1;
        pulses = 0;
        last = -1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (rdy[1]) begin
                pulses++;
                check("stream_rdata", rd[1], 32'h5A5A1234);
                if (last >= 0) check("stream_period", k - last, 5);
                else check("stream_first", k, W1 + 1);
                last = k;
                if (pulses == 5) req[1] = 1'b0;
            end
        end
        check("stream_pulses", pulses, 5);

        // Reset mid-WAIT drops the store.
        txn_check(1, 1'b1, 10'h020, 32'h22222222, 3'b010);
        @(negedge clk);
        we[1] = 1'b1; addr[1] = 10'h020; wd[1] = 32'h11111111; f3[1] = 3'b010; req[1] = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        req[1] = 1'b0;
        #1;
        check("rst_wait_ready", {31'b0, rdy[1]}, 32'h0);
        check("rst_wait_err",   {31'b0, err[1]}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        txn(1, 1'b0, 10'h020, 32'h0, 3'b010, r, e, lat);
        check("rst_wait_load", r, 32'h22222222);
        check("rst_wait_latency", lat, W1 + 1);

        // Reset during RESP clears outputs immediately.
        model(0, 1'b0, 10'h010, 32'h0, 3'b010, er, ee);
        @(negedge clk);
        we[0] = 1'b0; addr[0] = 10'h010; wd[0] = '0; f3[0] = 3'b010; req[0] = 1'b1;
        @(negedge clk);
        check("resp_ready", {31'b0, rdy[0]}, 32'h1);
        check("resp_rdata", rd[0], er);
        #2 reset = 1'b0;
        req[0] = 1'b0;
        #1;
        check("rst_resp_ready", {31'b0, rdy[0]}, 32'h0);
        check("rst_resp_rdata", rd[0], 32'h0);
        @(negedge clk);
        reset = 1'b1;
        txn_check(0, 1'b0, 10'h010, 32'h0, 3'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
